// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the 16-bit TSC CPU: sequences IF/ID/EX/MEM/WB,
// drives the ALU code and every datapath strobe, and counts retired instructions.
module mc_control_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    input  logic        bcond,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [5:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_src,
    output logic        wwd_en,
    output logic        halted,
    output logic [15:0] num_inst
);

    localparam logic [3:0] OP_BNE = 4'd0,  OP_BEQ = 4'd1,  OP_BGZ = 4'd2,  OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4,  OP_ORI = 4'd5,  OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7,  OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9,  OP_JAL = 4'd10, OP_RTYPE = 4'd15;

    localparam logic [5:0] FUNC_ADD = 6'd0,  FUNC_SUB = 6'd1,  FUNC_AND = 6'd2,  FUNC_ORR = 6'd3;
    localparam logic [5:0] FUNC_NOT = 6'd4,  FUNC_TCP = 6'd5,  FUNC_SHL = 6'd6,  FUNC_SHR = 6'd7;
    localparam logic [5:0] FUNC_ADI = 6'd8,  FUNC_ORI = 6'd9,  FUNC_LHI = 6'd10;
    localparam logic [5:0] FUNC_LWD = 6'd11, FUNC_SWD = 6'd12, FUNC_BPC = 6'd13;
    localparam logic [5:0] FUNC_JPR = 6'd25, FUNC_JRL = 6'd26, FUNC_WWD = 6'd28, FUNC_HLT = 6'd29;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_e;

    typedef enum logic [3:0] {
        C_NOP, C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH,
        C_JMP, C_JAL, C_JPR, C_JRL, C_WWD, C_HLT
    } iclass_e;

    state_e     state_q, state_d;
    iclass_e    iclass;
    logic [5:0] imm_op;
    logic       retire;

    logic [3:0] opcode;
    logic [5:0] func;
    logic       unused_fields;

    assign opcode        = instr[15:12];
    assign func          = instr[5:0];
    assign unused_fields = ^instr[11:6];

    // Instruction classification; anything unrecognised decodes to a retiring NOP.
    always_comb begin
        iclass = C_NOP;
        imm_op = FUNC_ADI;
        case (opcode)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: iclass = C_BRANCH;
            OP_ADI: begin iclass = C_ALU_I; imm_op = FUNC_ADI; end
            OP_ORI: begin iclass = C_ALU_I; imm_op = FUNC_ORI; end
            OP_LHI: begin iclass = C_ALU_I; imm_op = FUNC_LHI; end
            OP_LWD: iclass = C_LOAD;
            OP_SWD: iclass = C_STORE;
            OP_JMP: iclass = C_JMP;
            OP_JAL: iclass = C_JAL;
            OP_RTYPE: begin
                case (func)
                    FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_ORR,
                    FUNC_NOT, FUNC_TCP, FUNC_SHL, FUNC_SHR: iclass = C_ALU_R;
                    FUNC_JPR: iclass = C_JPR;
                    FUNC_JRL: iclass = C_JRL;
                    FUNC_WWD: iclass = C_WWD;
                    FUNC_HLT: iclass = C_HLT;
                    default:  iclass = C_NOP;
                endcase
            end
            default: iclass = C_NOP;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missed assignment here would infer a latch.
    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        alu_op    = 6'd0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        reg_write = 1'b0;
        reg_dst   = 2'd0;
        wb_src    = 2'd0;
        wwd_en    = 1'b0;
        halted    = 1'b0;

        // Gating with reset_n makes every output drop the instant reset asserts
        // and lets the first fetch request appear as soon as it releases.
        if (reset_n) begin
            case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_ID;
                    end
                end

                S_ID: begin
                    state_d = S_IF;
                    retire  = 1'b1;
                    case (iclass)
                        C_JMP: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd2;
                        end
                        C_JAL: begin
                            pc_write  = 1'b1;
                            pc_src    = 2'd2;
                            reg_write = 1'b1;
                            reg_dst   = 2'd2;
                            wb_src    = 2'd2;
                        end
                        C_JPR: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd3;
                        end
                        C_JRL: begin
                            pc_write  = 1'b1;
                            pc_src    = 2'd3;
                            reg_write = 1'b1;
                            reg_dst   = 2'd2;
                            wb_src    = 2'd2;
                        end
                        C_WWD: wwd_en = 1'b1;
                        C_HLT: state_d = S_HALT;
                        C_NOP: state_d = S_IF;
                        default: begin
                            retire  = 1'b0;
                            state_d = S_EX;
                        end
                    endcase
                end

                S_EX: begin
                    case (iclass)
                        C_ALU_R: begin
                            alu_op  = func;
                            state_d = S_WB;
                        end
                        C_ALU_I: begin
                            alu_op    = imm_op;
                            alu_src_b = 2'd1;
                            state_d   = S_WB;
                        end
                        C_LOAD: begin
                            alu_op    = FUNC_LWD;
                            alu_src_b = 2'd1;
                            state_d   = S_MEM;
                        end
                        C_STORE: begin
                            alu_op    = FUNC_SWD;
                            alu_src_b = 2'd1;
                            state_d   = S_MEM;
                        end
                        C_BRANCH: begin
                            alu_op    = FUNC_BPC;
                            alu_src_a = 1'b1;
                            alu_src_b = 2'd1;
                            pc_write  = bcond;
                            pc_src    = bcond ? 2'd1 : 2'd0;
                            retire    = 1'b1;
                            state_d   = S_IF;
                        end
                        default: state_d = S_IF;
                    endcase
                end

                S_MEM: begin
                    iord      = 1'b1;
                    mem_read  = (iclass == C_LOAD);
                    mem_write = (iclass != C_LOAD);
                    if (mem_ready) begin
                        if (iclass == C_LOAD) begin
                            state_d = S_WB;
                        end else begin
                            retire  = 1'b1;
                            state_d = S_IF;
                        end
                    end
                end

                S_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = (iclass == C_ALU_R) ? 2'd1 : 2'd0;
                    wb_src    = (iclass == C_LOAD) ? 2'd1 : 2'd0;
                    retire    = 1'b1;
                    state_d   = S_IF;
                end

                S_HALT: halted = 1'b1;

                default: state_d = S_IF;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IF;
            num_inst <= 16'd0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                num_inst <= num_inst + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class through the
// FSM and compares every strobe and the retire counter against hand-built values.
module tb_mc_control_unit;

    localparam logic [5:0] FUNC_ADD = 6'd0,  FUNC_SHR = 6'd7;
    localparam logic [5:0] FUNC_ADI = 6'd8,  FUNC_LWD = 6'd11;
    localparam logic [5:0] FUNC_SWD = 6'd12, FUNC_BPC = 6'd13;

    // Packed strobe word: {mem_read, mem_write, iord, ir_write, pc_write, pc_src,
    // alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, wb_src, wwd_en, halted}
    localparam logic [22:0] NONE = 23'd0;
    localparam logic [22:0] MR   = 23'd1 << 22;
    localparam logic [22:0] MW   = 23'd1 << 21;
    localparam logic [22:0] IORD = 23'd1 << 20;
    localparam logic [22:0] IRW  = 23'd1 << 19;
    localparam logic [22:0] PCW  = 23'd1 << 18;
    localparam logic [22:0] SA   = 23'd1 << 9;
    localparam logic [22:0] REGW = 23'd1 << 6;
    localparam logic [22:0] WWD  = 23'd1 << 1;
    localparam logic [22:0] HLTD = 23'd1;

    function automatic logic [22:0] f_pcsrc(input logic [1:0] v); return {5'd0, v, 16'd0};  endfunction
    function automatic logic [22:0] f_alu  (input logic [5:0] v); return {7'd0, v, 10'd0};  endfunction
    function automatic logic [22:0] f_srcb (input logic [1:0] v); return {14'd0, v, 7'd0};  endfunction
    function automatic logic [22:0] f_dst  (input logic [1:0] v); return {17'd0, v, 4'd0};  endfunction
    function automatic logic [22:0] f_wb   (input logic [1:0] v); return {19'd0, v, 2'd0};  endfunction

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instr;
    logic        mem_ready;
    logic        bcond;
    logic        mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic [5:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_src;
    logic        wwd_en, halted;
    logic [15:0] num_inst;
    logic [22:0] ctl;

    int total = 0;
    int bad   = 0;

    mc_control_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .instr     (instr),
        .mem_ready (mem_ready),
        .bcond     (bcond),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .iord      (iord),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_op    (alu_op),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .wb_src    (wb_src),
        .wwd_en    (wwd_en),
        .halted    (halted),
        .num_inst  (num_inst)
    );

    assign ctl = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_op,
                  alu_src_a, alu_src_b, reg_write, reg_dst, wb_src, wwd_en, halted};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are changed at the falling edge; outputs are sampled 1 time unit later.
    task automatic ctl_at(input string tag, input logic [22:0] exp);
        #1;
        check(tag, ctl, exp);
    endtask

    task automatic num_at(input string tag, input logic [15:0] exp);
        check(tag, {7'd0, num_inst}, {7'd0, exp});
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Zero-wait fetch from IF; leaves the FSM in ID.
    task automatic fetch(input string tag, input logic [15:0] word);
        instr     = word;
        mem_ready = 1'b1;
        ctl_at(tag, MR | IRW | PCW);
        nxt();
        mem_ready = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        instr     = 16'h0000;
        mem_ready = 1'b1;
        bcond     = 1'b0;
        nxt(); nxt(); nxt();
        ctl_at("reset_ctl", NONE);
        num_at("reset_num", 16'd0);
        mem_ready = 1'b0;

        // ADD r3,r1,r2 with two fetch wait states
        instr   = 16'hF6C0;
        reset_n = 1'b1;
        ctl_at("add_if_wait1", MR);
        nxt();
        ctl_at("add_if_wait2", MR);
        nxt();
        fetch("add_if_ready", 16'hF6C0);
        bcond     = 1'b1;
        mem_ready = 1'b1;
        ctl_at("add_id", NONE);
        nxt();
        bcond     = 1'b0;
        mem_ready = 1'b0;
        ctl_at("add_ex", f_alu(FUNC_ADD));
        nxt();
        ctl_at("add_wb", REGW | f_dst(2'd1));
        num_at("add_num_before", 16'd0);
        nxt();
        ctl_at("add_done_if", MR);
        num_at("add_num_after", 16'd1);

        // SHR r3,r1: func passes straight to alu_op
        fetch("shr_if", 16'hF6C7);
        nxt();
        ctl_at("shr_ex", f_alu(FUNC_SHR));
        nxt(); nxt();
        num_at("shr_num", 16'd2);

        // LWD r1,0x05(r0) with a one-cycle MEM wait
        fetch("lwd_if", 16'h7105);
        ctl_at("lwd_id", NONE);
        nxt();
        ctl_at("lwd_ex", f_alu(FUNC_LWD) | f_srcb(2'd1));
        nxt();
        ctl_at("lwd_mem_wait", MR | IORD);
        nxt();
        mem_ready = 1'b1;
        ctl_at("lwd_mem_ready", MR | IORD);
        nxt();
        mem_ready = 1'b0;
        ctl_at("lwd_wb", REGW | f_dst(2'd0) | f_wb(2'd1));
        nxt();
        ctl_at("lwd_done_if", MR);
        num_at("lwd_num", 16'd3);

        // SWD: no WB cycle, retires out of MEM
        fetch("swd_if", 16'h8105);
        nxt();
        ctl_at("swd_ex", f_alu(FUNC_SWD) | f_srcb(2'd1));
        nxt();
        mem_ready = 1'b1;
        ctl_at("swd_mem", MW | IORD);
        nxt();
        mem_ready = 1'b0;
        ctl_at("swd_done_if", MR);
        num_at("swd_num", 16'd4);

        // BEQ taken, then not taken with stray mem_ready in ID/EX
        fetch("beq_t_if", 16'h1105);
        nxt();
        bcond = 1'b1;
        ctl_at("beq_t_ex", f_alu(FUNC_BPC) | SA | f_srcb(2'd1) | PCW | f_pcsrc(2'd1));
        nxt();
        bcond = 1'b0;
        ctl_at("beq_t_done_if", MR);
        num_at("beq_t_num", 16'd5);

        fetch("beq_n_if", 16'h1105);
        mem_ready = 1'b1;
        ctl_at("beq_n_id", NONE);
        nxt();
        ctl_at("beq_n_ex", f_alu(FUNC_BPC) | SA | f_srcb(2'd1));
        nxt();
        mem_ready = 1'b0;
        ctl_at("beq_n_done_if", MR);
        num_at("beq_n_num", 16'd6);

        // Jumps and WWD retire out of ID
        fetch("jal_if", 16'hA123);
        ctl_at("jal_id", PCW | f_pcsrc(2'd2) | REGW | f_dst(2'd2) | f_wb(2'd2));
        nxt();
        num_at("jal_num", 16'd7);

        fetch("wwd_if", 16'hF01C);
        ctl_at("wwd_id", WWD);
        nxt();
        ctl_at("wwd_gone", MR);
        num_at("wwd_num", 16'd8);

        fetch("jpr_if", 16'hF019);
        ctl_at("jpr_id", PCW | f_pcsrc(2'd3));
        nxt();
        fetch("jrl_if", 16'hF01A);
        ctl_at("jrl_id", PCW | f_pcsrc(2'd3) | REGW | f_dst(2'd2) | f_wb(2'd2));
        nxt();
        num_at("jrl_num", 16'd10);

        // Unknown opcode and unknown func act as retiring NOPs
        fetch("unk_op_if", 16'hB000);
        ctl_at("unk_op_id", NONE);
        nxt();
        ctl_at("unk_op_done", MR);
        fetch("unk_fn_if", 16'hF008);
        ctl_at("unk_fn_id", NONE);
        nxt();
        ctl_at("unk_fn_done", MR);
        num_at("unk_num", 16'd12);

        // ADI: immediate ALU op, I-type write-back
        fetch("adi_if", 16'h4105);
        nxt();
        ctl_at("adi_ex", f_alu(FUNC_ADI) | f_srcb(2'd1));
        nxt();
        ctl_at("adi_wb", REGW);
        nxt();
        num_at("adi_num", 16'd13);

        // Counter wrap: preload 0xFFFF while idling in IF, then retire a WWD
        force dut.num_inst = 16'hFFFF;
        nxt();
        release dut.num_inst;
        #1;
        num_at("wrap_preload", 16'hFFFF);
        fetch("wrap_if", 16'hF01C);
        nxt();
        num_at("wrap_num", 16'h0000);

        // HLT retires, then the FSM ignores memory forever
        fetch("hlt_if", 16'hF01D);
        ctl_at("hlt_id", NONE);
        nxt();
        ctl_at("halt_state", HLTD);
        num_at("halt_num", 16'd1);
        mem_ready = 1'b1;
        nxt();
        ctl_at("halt_ready1", HLTD);
        nxt();
        ctl_at("halt_ready2", HLTD);
        mem_ready = 1'b0;
        num_at("halt_num_hold", 16'd1);

        // Asynchronous reset out of HALT
        reset_n = 1'b0;
        ctl_at("halt_rst_ctl", NONE);
        num_at("halt_rst_num", 16'd0);
        nxt();
        reset_n = 1'b1;
        ctl_at("halt_rst_release", MR);

        // Retire one WWD, then reset in the middle of a SWD memory wait
        fetch("pre_wwd_if", 16'hF01C);
        nxt();
        fetch("mid_swd_if", 16'h8105);
        nxt(); nxt();
        ctl_at("mid_swd_mem", MW | IORD);
        num_at("mid_swd_num", 16'd1);
        reset_n = 1'b0;
        ctl_at("mid_rst_ctl", NONE);
        num_at("mid_rst_num", 16'd0);
        nxt();
        reset_n = 1'b1;
        ctl_at("mid_rst_restart", MR);
        fetch("restart_if", 16'hF01C);
        ctl_at("restart_id", WWD);
        nxt();
        num_at("restart_num", 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control FSM for the 16-bit TSC CPU. It sequences fetch, decode, execute, memory and write-back for each instruction, and drives the ALU operation code (`FUNC_*` encoding from `opcodes.v`) and all datapath strobes. It handshakes with the unified memory port and counts retired instructions. It sits between the instruction register/branch comparator and the datapath muxes, register file, ALU and memory interface.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `instr` in 16: IR contents: opcode[15:12], rs[11:10], rt[9:8], rd[7:6], func[5:0].
- `mem_ready` in 1: one-cycle pulse; read data valid, or write accepted.
- `bcond` in 1: branch condition from the datapath comparator, valid in EX.
- `mem_read`, `mem_write` out 1: memory request; held until `mem_ready`.
- `iord` out 1: memory address select (0 = PC, 1 = ALU out).
- `ir_write` out 1: latch `instr` from the memory data bus.
- `pc_write` out 1: PC update strobe.
- `pc_src` out 2: next-PC select (0 = PC+1, 1 = ALU out, 2 = {PC[15:12], target[11:0]}, 3 = rs value).
- `alu_op` out 6: `FUNC_*` code.
- `alu_src_a` out 1: ALU A select (0 = rs, 1 = old PC).
- `alu_src_b` out 2: ALU B select (0 = rt, 1 = imm[7:0]).
- `reg_write` out 1: register-file write strobe.
- `reg_dst` out 2: write register (0 = rt, 1 = rd, 2 = r2).
- `wb_src` out 2: write-back data (0 = ALU out, 1 = MDR, 2 = PC).
- `wwd_en` out 1: one-cycle output-port strobe.
- `halted` out 1: high in HALT.
- `num_inst` out 16: retired-instruction count.

## Operation
- States: IF, ID, EX, MEM, WB, HALT.
- IF:
  - Drive `mem_read=1`, `iord=0`.
  - Stay in IF until `mem_ready`.
  - On the `mem_ready` cycle: `ir_write=1`, `pc_write=1`, `pc_src=0`. Go to ID.
- ID: decode `instr`.
  - JMP: `pc_write`, `pc_src=2`; retire; go to IF.
  - JAL: as JMP, plus `reg_write`, `reg_dst=2`, `wb_src=2`; retire; go to IF.
  - JPR: `pc_write`, `pc_src=3`; retire; go to IF.
  - JRL: as JPR, plus `reg_write` to r2 with PC; retire; go to IF.
  - WWD: `wwd_en=1`; retire; go to IF.
  - HLT: retire; go to HALT.
  - Unknown opcode or func: NOP; retire; go to IF.
  - All others: go to EX.
- EX: drive `alu_op` by instruction type.
  - R-type arithmetic/logic: `alu_op` = func (ADD/SUB/AND/ORR/NOT/TCP/SHL/SHR), `alu_src_b=0`; go to WB.
  - ADI/ORI/LHI: `FUNC_ADI`/`FUNC_ORI`/`FUNC_LHI`, `alu_src_b=1`; go to WB.
  - LWD/SWD: `FUNC_LWD`/`FUNC_SWD`, `alu_src_b=1`; go to MEM.
  - BNE/BEQ/BGZ/BLZ: `FUNC_BPC`, `alu_src_a=1`, `alu_src_b=1`. If `bcond`, also `pc_write`, `pc_src=1`. Retire; go to IF.
- MEM:
  - Drive `iord=1`, plus `mem_read` (LWD) or `mem_write` (SWD), until `mem_ready`.
  - LWD then goes to WB.
  - SWD retires and goes to IF.
- WB:
  - `reg_write=1`.
  - `reg_dst=1` for R-type, 0 for I-type.
  - `wb_src=1` for LWD, else 0.
  - Retire; go to IF.
- HALT: absorbing state; all strobes 0, `halted=1`. Only reset exits it.
- Retire: `num_inst` increments by 1 at the clock edge that leaves the retiring state, wrapping 0xFFFF -> 0x0000. HLT is counted.
- Unlisted outputs are 0 in every state.

## Timing
- Reset:
  - While `reset_n=0`: state = IF, `num_inst=0`, every output forced to 0, including `mem_read`.
  - Reset release takes effect asynchronously. First fetch request is asserted in the cycle after release.
- Reset mid-operation: state and counter clear immediately. Any in-flight memory request drops the same cycle.
- Outputs are Moore/state-decoded. `ir_write`, `pc_write` in IF, and the MEM-exit transition are qualified combinationally by `mem_ready`.
- Latency with `mem_ready` in the first request cycle (wait states add 1 cycle each):
  - ADD: 4 cycles. LWD: 5. SWD: 4. Branch: 3. JMP/JAL/JPR/JRL/WWD: 2.
- `mem_read` and `mem_write` are never high together.
- `mem_ready` outside IF/MEM is ignored.
- `bcond` is sampled only in EX of branches.

## Test plan
- Reset: hold `reset_n=0` 3 cycles -> all outputs 0, `num_inst=0`. Release -> `mem_read=1`, `iord=0` next cycle.
- ADD r3,r1,r2 (`instr`=0xF6C0), `mem_ready` in IF after 2 wait cycles -> IF lasts 3 cycles, then ID, then EX (`alu_op`=`FUNC_ADD`), then WB (`reg_write=1`, `reg_dst=1`). `num_inst` 0 -> 1.
- LWD r1,0x05(r0) with a 1-cycle MEM wait -> MEM holds `mem_read=1`, `iord=1` for 2 cycles; WB has `wb_src=1`, `reg_dst=0`. SWD -> `mem_write=1`, no WB cycle.
- BEQ with `bcond=1` -> EX: `alu_op`=`FUNC_BPC`, `alu_src_a=1`, `pc_write=1`, `pc_src=1`. With `bcond=0` -> no `pc_write`. Both retire in 3 cycles.
- JAL 0x123 -> ID: `pc_write`, `pc_src=2`, `reg_write`, `reg_dst=2`, `wb_src=2`. WWD -> single `wwd_en` pulse.
- HLT -> `halted=1` permanently, no `mem_read` despite `mem_ready` pulses, count +1. Preload `num_inst=0xFFFF` and retire one more -> 0x0000. Pulse `reset_n` low in MEM -> `mem_write` drops immediately, restart in IF.
